// File: rtl/timer_pkg.sv
// Shared constants, types and width helpers for the interval timer.
package timer_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
    localparam int unsigned DEFAULT_SEC_W  = 5;

    typedef logic [DEFAULT_SEC_W-1:0] sec_default_t;

    // Prescaler register width; never below 1 bit.
    function automatic int unsigned presc_w(input int unsigned hz);
        return (hz < 32'd2) ? 32'd1 : 32'($clog2(hz));
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ cycles; freezes on hold.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int unsigned   PW = presc_w(CLK_HZ);
    localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc;
    logic          at_tc;

    assign at_tc = (presc == TC);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            presc <= '0;
        end else if (!hold) begin
            presc <= at_tc ? '0 : presc + PW'(1);
        end
    end

    // Tick is suppressed on any edge where the counter will not advance normally.
    assign tick = at_tc & ~hold & ~clr & ~reset;

endmodule

// File: rtl/interval_timer.sv
// Saturating seconds timer with short/long timeout flags.
// Optional macro TIMER_EXPIRY_PULSE_EN adds one-cycle TS_pulse/TL_pulse outputs.
module interval_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEFAULT_CLK_HZ,
    parameter int unsigned SEC_W     = DEFAULT_SEC_W,
    parameter int unsigned SHORT_SEC = 5,
    parameter int unsigned LONG_SEC  = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ST,
    input  logic             hold,
    output logic             tick,
    output logic             TS,
    output logic             TL,
    output logic [SEC_W-1:0] seconds
`ifdef TIMER_EXPIRY_PULSE_EN
    ,
    output logic             TS_pulse,
    output logic             TL_pulse
`endif
);

    typedef logic [SEC_W-1:0] sec_t;

    localparam longint unsigned SEC_LIMIT = (64'd1 << SEC_W) - 64'd1;
    localparam sec_t            SEC_MAX   = '1;
    localparam sec_t            SHORT_V   = SEC_W'(SHORT_SEC);
    localparam sec_t            LONG_V    = SEC_W'(LONG_SEC);

    if (CLK_HZ < 2) begin : g_bad_clk
        $error("interval_timer: CLK_HZ must be >= 2");
    end
    if (SHORT_SEC >= LONG_SEC) begin : g_bad_order
        $error("interval_timer: SHORT_SEC must be below LONG_SEC");
    end
    if (64'(LONG_SEC) > SEC_LIMIT) begin : g_bad_long
        $error("interval_timer: LONG_SEC does not fit in SEC_W bits");
    end

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (ST),
        .hold  (hold),
        .tick  (tick)
    );

    sec_t sec_q;

    // Seconds count up on tick and stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || ST) begin
            sec_q <= '0;
        end else if (tick && (sec_q != SEC_MAX)) begin
            sec_q <= sec_q + SEC_W'(1);
        end
    end

    assign seconds = sec_q;
    assign TS      = (sec_q >= SHORT_V);
    assign TL      = (sec_q >= LONG_V);

`ifdef TIMER_EXPIRY_PULSE_EN
    localparam sec_t SHORT_PRE = SEC_W'(SHORT_SEC - 1);
    localparam sec_t LONG_PRE  = SEC_W'(LONG_SEC - 1);

    // Seconds only ever step by one, so hitting the threshold from one below is the first crossing.
    always_ff @(posedge clk) begin
        if (reset || ST) begin
            TS_pulse <= 1'b0;
            TL_pulse <= 1'b0;
        end else begin
            TS_pulse <= tick && (sec_q == SHORT_PRE);
            TL_pulse <= tick && (sec_q == LONG_PRE);
        end
    end
`else
    // Level flags only in this build.
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: main instance (SEC_W=5) and a saturation instance (SEC_W=3).
module tb_interval_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, st_a, hold_a;
    logic       tick_a, ts_a, tl_a;
    logic [4:0] sec_a;
    logic       reset_s, st_s, hold_s;
    logic       tick_s, ts_s, tl_s;
    logic [2:0] sec_s;
`ifdef TIMER_EXPIRY_PULSE_EN
    logic       tsp_a, tlp_a, tsp_s, tlp_s;
`endif

    int checks = 0;
    int errors = 0;

    interval_timer #(.CLK_HZ(4), .SEC_W(5), .SHORT_SEC(2), .LONG_SEC(5)) dut (
        .clk      (clk),
        .reset    (reset_a),
        .ST       (st_a),
        .hold     (hold_a),
        .tick     (tick_a),
        .TS       (ts_a),
        .TL       (tl_a),
        .seconds  (sec_a)
`ifdef TIMER_EXPIRY_PULSE_EN
        ,
        .TS_pulse (tsp_a),
        .TL_pulse (tlp_a)
`endif
    );

    interval_timer #(.CLK_HZ(4), .SEC_W(3), .SHORT_SEC(2), .LONG_SEC(6)) dut_s (
        .clk      (clk),
        .reset    (reset_s),
        .ST       (st_s),
        .hold     (hold_s),
        .tick     (tick_s),
        .TS       (ts_s),
        .TL       (tl_s),
        .seconds  (sec_s)
`ifdef TIMER_EXPIRY_PULSE_EN
        ,
        .TS_pulse (tsp_s),
        .TL_pulse (tlp_s)
`endif
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_a = 1'b1; st_a = 1'b0; hold_a = 1'b0;
        reset_s = 1'b1; st_s = 1'b0; hold_s = 1'b0;

        // Reset state
        cyc(2);
        check("rst_sec", 32'(sec_a), 0);
        check("rst_tick", 32'(tick_a), 0);
        check("rst_ts", 32'(ts_a), 0);
        check("rst_tl", 32'(tl_a), 0);
        check("rst_s_sec", 32'(sec_s), 0);

        // Free run from reset release
        reset_a = 1'b0;
        cyc(1);
        check("run_e1_tick", 32'(tick_a), 0);
        cyc(2);
        check("run_e3_tick", 32'(tick_a), 1);
        check("run_e3_sec", 32'(sec_a), 0);
        cyc(1);
        check("run_e4_sec", 32'(sec_a), 1);
        check("run_e4_tick", 32'(tick_a), 0);
        cyc(3);
        check("run_e7_ts", 32'(ts_a), 0);
        check("run_e7_tick", 32'(tick_a), 1);
`ifdef TIMER_EXPIRY_PULSE_EN
        check("run_e7_tsp", 32'(tsp_a), 0);
`endif
        cyc(1);
        check("run_e8_ts", 32'(ts_a), 1);
        check("run_e8_sec", 32'(sec_a), 2);
`ifdef TIMER_EXPIRY_PULSE_EN
        check("run_e8_tsp", 32'(tsp_a), 1);
        cyc(1);
        check("run_e9_tsp", 32'(tsp_a), 0);
        cyc(10);
`else
        cyc(11);
`endif
        check("run_e19_tl", 32'(tl_a), 0);
        check("run_e19_sec", 32'(sec_a), 4);
        cyc(1);
        check("run_e20_tl", 32'(tl_a), 1);
        check("run_e20_sec", 32'(sec_a), 5);
`ifdef TIMER_EXPIRY_PULSE_EN
        check("run_e20_tlp", 32'(tlp_a), 1);
        cyc(1);
        check("run_e21_tlp", 32'(tlp_a), 0);
        check("run_e21_tl", 32'(tl_a), 1);
`endif

        // ST clears, and held ST keeps it cleared
        st_a = 1'b1;
        cyc(1);
        check("st_sec", 32'(sec_a), 0);
        check("st_ts", 32'(ts_a), 0);
        check("st_tl", 32'(tl_a), 0);
        cyc(5);
        check("st_held_sec", 32'(sec_a), 0);
        check("st_held_tick", 32'(tick_a), 0);
        st_a = 1'b0;
        cyc(14);
        check("pre_st_sec", 32'(sec_a), 3);
        check("pre_st_ts", 32'(ts_a), 1);
        st_a = 1'b1;
        cyc(1);
        check("st2_sec", 32'(sec_a), 0);
        check("st2_ts", 32'(ts_a), 0);
        st_a = 1'b0;
        cyc(7);
        check("st2_e7_ts", 32'(ts_a), 0);
        check("st2_e7_sec", 32'(sec_a), 1);
        cyc(1);
        check("st2_e8_ts", 32'(ts_a), 1);
`ifdef TIMER_EXPIRY_PULSE_EN
        check("st2_e8_tsp", 32'(tsp_a), 1);
`endif

        // Hold at presc=2, seconds=1
        st_a = 1'b1;
        cyc(1);
        st_a = 1'b0;
        cyc(6);
        check("hold_pre_sec", 32'(sec_a), 1);
        hold_a = 1'b1;
        #1;
        check("hold_tick0", 32'(tick_a), 0);
        cyc(10);
        check("hold_sec", 32'(sec_a), 1);
        check("hold_tick", 32'(tick_a), 0);
        hold_a = 1'b0;
        cyc(1);
        check("unhold_tick", 32'(tick_a), 1);
        check("unhold_sec", 32'(sec_a), 1);
        hold_a = 1'b1;
        #1;
        check("hold_tc_tick", 32'(tick_a), 0);
        cyc(2);
        check("hold_tc_sec", 32'(sec_a), 1);
        hold_a = 1'b0;
        #1;
        check("release_tick", 32'(tick_a), 1);
        cyc(1);
        check("release_sec", 32'(sec_a), 2);
        check("release_ts", 32'(ts_a), 1);

        // Reset and ST together in a tick cycle
        cyc(3);
        check("both_pre_tick", 32'(tick_a), 1);
        reset_a = 1'b1;
        st_a    = 1'b1;
        #1;
        check("both_tick_c", 32'(tick_a), 0);
        cyc(1);
        check("both_sec", 32'(sec_a), 0);
        check("both_tick", 32'(tick_a), 0);
        check("both_ts", 32'(ts_a), 0);
        check("both_tl", 32'(tl_a), 0);
        reset_a = 1'b0;
        st_a    = 1'b0;

        // Saturation on the 3-bit instance
        reset_s = 1'b0;
        cyc(23);
        check("sat_e23_tl", 32'(tl_s), 0);
        cyc(1);
        check("sat_e24_tl", 32'(tl_s), 1);
        check("sat_e24_sec", 32'(sec_s), 6);
`ifdef TIMER_EXPIRY_PULSE_EN
        check("sat_e24_tlp", 32'(tlp_s), 1);
`endif
        cyc(4);
        check("sat_e28_sec", 32'(sec_s), 7);
        cyc(3);
        check("sat_e31_tick", 32'(tick_s), 1);
        cyc(1);
        check("sat_e32_sec", 32'(sec_s), 7);
        cyc(3);
        check("sat_e35_tick", 32'(tick_s), 1);
        cyc(1);
        check("sat_e36_sec", 32'(sec_s), 7);
        check("sat_e36_tl", 32'(tl_s), 1);
        check("sat_e36_ts", 32'(ts_s), 1);
`ifdef TIMER_EXPIRY_PULSE_EN
        check("sat_e36_tsp", 32'(tsp_s), 0);
        check("sat_e36_tlp", 32'(tlp_s), 0);
`endif
        hold_s = 1'b1;
        cyc(5);
        check("sat_hold_sec", 32'(sec_s), 7);
        check("sat_hold_tick", 32'(tick_s), 0);
        check("sat_hold_tl", 32'(tl_s), 1);
`ifdef TIMER_EXPIRY_PULSE_EN
        check("sat_hold_tlp", 32'(tlp_s), 0);
`endif
        hold_s = 1'b0;
        cyc(4);
        check("sat_after_sec", 32'(sec_s), 7);
`ifdef TIMER_EXPIRY_PULSE_EN
        check("sat_after_tsp", 32'(tsp_s), 0);
        check("sat_after_tlp", 32'(tlp_s), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
